// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
//   Shared encodings for the MEM-stage load/store path.
//   - size_e  : access size as carried on req_size (byte/half/word/illegal)
//   - state_e : control states of the load/store initiator
//   - BYTE_W / HALF_W and their sign-bit positions, used for lane slicing
//     and sign extension of returned load data
//   - is_misaligned(): alignment/legality check of a request
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Lane widths and the bit positions that carry the sign of each lane.
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned HALF_W    = 16;
  localparam int unsigned BYTE_SIGN = BYTE_W - 1;
  localparam int unsigned HALF_SIGN = HALF_W - 1;

  // A half must sit on an even address, a word on a multiple of four.
  // The reserved size encoding is reported the same way as a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
//   Combinational size/signedness extension of right-aligned load data.
//   Kept standalone so forwarding logic can apply the same extension.
//
//   Ports
//     size        in  2       access size (size_e encoding)
//     is_unsigned in  1       1 = zero-extend (lbu/lhu), 0 = sign-extend
//     rdata       in  DATA_W  right-aligned lane from memory
//     ext_data    out DATA_W  extended result; words pass through
// -----------------------------------------------------------------------------
module load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ext_data
);

  logic byte_fill;
  logic half_fill;

  // NOTE: every variable written in always_comb gets a value before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    ext_data  = rdata;
    byte_fill = ~is_unsigned & rdata[BYTE_SIGN];
    half_fill = ~is_unsigned & rdata[HALF_SIGN];
    case (size)
      SIZE_BYTE: ext_data = {{(DATA_W - BYTE_W){byte_fill}}, rdata[BYTE_W-1:0]};
      SIZE_HALF: ext_data = {{(DATA_W - HALF_W){half_fill}}, rdata[HALF_W-1:0]};
      default:   ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store initiator of the MEM stage. Takes one request at a time,
//   drives the data-memory strobes for a single cycle, waits out the
//   memory's registered read latency, extends the returned lane and emits
//   one response pulse with misalignment/range flags.
//
//   Ports
//     clk, rst                 clock (rising edge), async active-low reset
//     req_valid/req_ready      request handshake; ready only while idle
//     req_write                1 = store, 0 = load
//     req_size                 00 byte, 01 half, 10 word, 11 illegal
//     req_unsigned             loads: zero-extend instead of sign-extend
//     req_addr, req_wdata      byte address, right-aligned store data
//     rsp_valid                one-cycle response pulse
//     rsp_rdata                extended load data (0 for stores/errors)
//     rsp_misaligned/rsp_fault error flags, held until the next response
//     busy                     pipeline stall while an access is in flight
//     mem_addr/mem_wdata       address and store data to memory
//     mem_read/mem_write       MemRead/MemWrite, high for one cycle
//     mem_half/mem_byte        HalfOperation/ByteOperation lane strobes
//     mem_rdata                right-aligned, zero-extended read lane
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_BYTES  = 256,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_misaligned,
  output logic              rsp_fault,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_half,
  output logic              mem_byte,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  size_e             size_q;
  logic              unsigned_q;
  logic [DATA_W-1:0] ext_data;

  // ---------------------------------------------------------------------------
  // Request checks, evaluated on the request as presented in IDLE.
  // ---------------------------------------------------------------------------
  logic req_misaligned;
  logic req_fault;
  logic req_err;

  assign req_misaligned = is_misaligned(req_size, req_addr[1:0]);
  assign req_fault      = (req_addr >= ADDR_W'(MEM_BYTES));
  assign req_err        = req_misaligned | req_fault;

  // ---------------------------------------------------------------------------
  // Extension of the returned lane, using the size captured at acceptance.
  // ---------------------------------------------------------------------------
  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .rdata       (mem_rdata),
    .ext_data    (ext_data)
  );

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs. Handshake/stall outputs come
  // straight from the state so an asynchronous reset clears them at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_d = req_err ? ST_RESP : ST_ISSUE;
      end
      // Stores complete with the strobe; loads wait for the read data.
      ST_ISSUE: state_d = mem_write ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory-port and response registers.
  // The strobes are set on acceptance and cleared on leaving ISSUE, so they
  // are high for exactly the ISSUE cycle. Response registers change only on
  // the edge that enters RESP, so they hold their value between responses.
  // ---------------------------------------------------------------------------
  // NOTE: the address/data registers are reset along with the strobes; the
  // memory port must present all zeros while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_half       <= 1'b0;
      mem_byte       <= 1'b0;
      cnt_q          <= '0;
      size_q         <= SIZE_BYTE;
      unsigned_q     <= 1'b0;
      rsp_rdata      <= '0;
      rsp_misaligned <= 1'b0;
      rsp_fault      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_err) begin
              // Rejected request: report directly, memory is never touched.
              rsp_rdata      <= '0;
              rsp_misaligned <= req_misaligned;
              rsp_fault      <= req_fault;
            end else begin
              mem_addr   <= req_addr;
              mem_wdata  <= req_wdata;
              mem_half   <= (req_size == SIZE_HALF);
              mem_byte   <= (req_size == SIZE_BYTE);
              mem_read   <= ~req_write;
              mem_write  <= req_write;
              size_q     <= size_e'(req_size);
              unsigned_q <= req_unsigned;
            end
          end
        end
        ST_ISSUE: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          mem_half  <= 1'b0;
          mem_byte  <= 1'b0;
          cnt_q     <= CNT_W'(RD_LATENCY);
          if (mem_write) begin
            rsp_rdata      <= '0;
            rsp_misaligned <= 1'b0;
            rsp_fault      <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            rsp_rdata      <= ext_data;
            rsp_misaligned <= 1'b0;
            rsp_fault      <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_fault;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic        mem_half;
  logic        mem_byte;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_init = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_BYTES  (256),
    .RD_LATENCY (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_misaligned (rsp_misaligned),
    .rsp_fault      (rsp_fault),
    .busy           (busy),
    .mem_addr       (mem_addr),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_half       (mem_half),
    .mem_byte       (mem_byte),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // Little-endian data memory, one-cycle registered read, lane returned
  // right-aligned and zero-extended.
  logic [7:0] mem [0:255];

  always @(posedge clk) begin
    int a;
    a = int'(mem_addr & 32'h000000FF);
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0] <= 8'd17;
      mem[4] <= 8'd9;
      mem[8] <= 8'd25;
    end else begin
      if (mem_write) begin
        mem[a] <= mem_wdata[7:0];
        if (!mem_byte) begin
          mem[(a + 1) & 255] <= mem_wdata[15:8];
          if (!mem_half) begin
            mem[(a + 2) & 255] <= mem_wdata[23:16];
            mem[(a + 3) & 255] <= mem_wdata[31:24];
          end
        end
      end
      if (mem_read) begin
        if (mem_byte)      mem_rdata <= {24'h0, mem[a]};
        else if (mem_half) mem_rdata <= {16'h0, mem[(a + 1) & 255], mem[a]};
        else               mem_rdata <= {mem[(a + 3) & 255], mem[(a + 2) & 255],
                                         mem[(a + 1) & 255], mem[a]};
      end
    end
  end

  // Scoreboard: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rdata=%h mis=%b flt=%b, no response expected",
                 rsp_rdata, rsp_misaligned, rsp_fault);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_misaligned !== e.mis || rsp_fault !== e.flt) begin
          errors++;
          $display("FAIL %s: got rdata=%h mis=%b flt=%b, want rdata=%h mis=%b flt=%b",
                   e.name, rsp_rdata, rsp_misaligned, rsp_fault, e.rdata, e.mis, e.flt);
        end
      end
    end
  end

  // One request from IDLE to its response, with latency, strobe and port checks.
  task automatic send(input string name, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_mis, input logic exp_flt);
    exp_t e;
    int   lat, rd_cnt, wr_cnt, wait_cnt, exp_lat;
    logic got, err;
    logic [31:0] obs_addr, obs_wdata;
    logic obs_half, obs_byte;
    err = exp_mis | exp_flt;
    exp_lat = err ? 1 : (wr ? 2 : 3);
    wait_cnt = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    e.rdata = exp_rd; e.mis = exp_mis; e.flt = exp_flt; e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd_cnt = 0; wr_cnt = 0; got = 1'b0;
    obs_addr = 'x; obs_wdata = 'x; obs_half = 1'bx; obs_byte = 1'bx;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_read === 1'b1) rd_cnt++;
      if (mem_write === 1'b1) wr_cnt++;
      if (mem_read === 1'b1 || mem_write === 1'b1) begin
        obs_addr = mem_addr; obs_wdata = mem_wdata;
        obs_half = mem_half; obs_byte = mem_byte;
      end
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: rsp after %0d cycles (seen=%b), want %0d", name, lat, got, exp_lat);
    end
    checks++;
    if (rd_cnt != ((!err && !wr) ? 1 : 0) || wr_cnt != ((!err && wr) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_strobes: read cycles=%0d write cycles=%0d, want %0d/%0d", name,
               rd_cnt, wr_cnt, (!err && !wr) ? 1 : 0, (!err && wr) ? 1 : 0);
    end
    if (!err) begin
      checks++;
      if (obs_addr !== addr || obs_half !== (sz == 2'b01) || obs_byte !== (sz == 2'b00) ||
          (wr && obs_wdata !== wd)) begin
        errors++;
        $display("FAIL %s_port: addr=%h half=%b byte=%b wdata=%h, want addr=%h half=%b byte=%b wdata=%h",
                 name, obs_addr, obs_half, obs_byte, obs_wdata, addr, sz == 2'b01, sz == 2'b00, wd);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after: rsp_valid=%b req_ready=%b busy=%b, want 0/1/0",
               name, rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_read, mem_write, mem_half, mem_byte} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        rsp_valid !== 1'b0 || rsp_misaligned !== 1'b0 || rsp_fault !== 1'b0 ||
        rsp_rdata !== '0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: strobes=%b addr=%h wdata=%h rsp=%b%b%b rdata=%h busy=%b ready=%b, want all 0, ready 1",
               {mem_read, mem_write, mem_half, mem_byte}, mem_addr, mem_wdata,
               rsp_valid, rsp_misaligned, rsp_fault, rsp_rdata, busy, req_ready);
    end
    rst = 1'b1;
  endtask

  task automatic test_load_word();
    send("lw_8", 1'b0, 2'b10, 1'b0, 32'd8, '0, 32'h0000_0019, 1'b0, 1'b0);
    send("lw_0", 1'b0, 2'b10, 1'b0, 32'd0, '0, 32'h0000_0011, 1'b0, 1'b0);
    send("lw_4", 1'b0, 2'b10, 1'b0, 32'd4, '0, 32'h0000_0009, 1'b0, 1'b0);
  endtask

  task automatic test_byte_access();
    send("sb_4",  1'b1, 2'b00, 1'b0, 32'd4, 32'h0000_FF80, 32'h0, 1'b0, 1'b0);
    send("lb_4",  1'b0, 2'b00, 1'b0, 32'd4, '0, 32'hFFFF_FF80, 1'b0, 1'b0);
    send("lbu_4", 1'b0, 2'b00, 1'b1, 32'd4, '0, 32'h0000_0080, 1'b0, 1'b0);
    send("lb_5",  1'b0, 2'b00, 1'b0, 32'd5, '0, 32'h0000_0000, 1'b0, 1'b0);
    send("sb_7",  1'b1, 2'b00, 1'b0, 32'd7, 32'h1234_567F, 32'h0, 1'b0, 1'b0);
    send("lb_7",  1'b0, 2'b00, 1'b0, 32'd7, '0, 32'h0000_007F, 1'b0, 1'b0);
  endtask

  task automatic test_half_word_access();
    send("sh_12",  1'b1, 2'b01, 1'b0, 32'd12, 32'h0000_8001, 32'h0, 1'b0, 1'b0);
    send("lh_12",  1'b0, 2'b01, 1'b0, 32'd12, '0, 32'hFFFF_8001, 1'b0, 1'b0);
    send("lhu_12", 1'b0, 2'b01, 1'b1, 32'd12, '0, 32'h0000_8001, 1'b0, 1'b0);
    send("sh_254", 1'b1, 2'b01, 1'b0, 32'd254, 32'h1234_ABCD, 32'h0, 1'b0, 1'b0);
    send("lh_254", 1'b0, 2'b01, 1'b0, 32'd254, '0, 32'hFFFF_ABCD, 1'b0, 1'b0);
    send("lw_252", 1'b0, 2'b10, 1'b0, 32'd252, '0, 32'hABCD_0000, 1'b0, 1'b0);
    send("lb_255", 1'b0, 2'b00, 1'b0, 32'd255, '0, 32'hFFFF_FFAB, 1'b0, 1'b0);
    send("sw_16",  1'b1, 2'b10, 1'b0, 32'd16, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    send("lw_16",  1'b0, 2'b10, 1'b0, 32'd16, '0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    send("lh_18",  1'b0, 2'b01, 1'b0, 32'd18, '0, 32'hFFFF_DEAD, 1'b0, 1'b0);
    send("lbu_17", 1'b0, 2'b00, 1'b1, 32'd17, '0, 32'h0000_00BE, 1'b0, 1'b0);
  endtask

  task automatic test_errors();
    send("lw_6_mis",     1'b0, 2'b10, 1'b0, 32'd6, '0, 32'h0, 1'b1, 1'b0);
    send("lh_3_mis",     1'b0, 2'b01, 1'b0, 32'd3, '0, 32'h0, 1'b1, 1'b0);
    send("size11_mis",   1'b0, 2'b11, 1'b0, 32'd0, '0, 32'h0, 1'b1, 1'b0);
    send("sw_2_mis",     1'b1, 2'b10, 1'b0, 32'd2, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b0);
    send("lw_100_fault", 1'b0, 2'b10, 1'b0, 32'h100, '0, 32'h0, 1'b0, 1'b1);
    send("lw_102_both",  1'b0, 2'b10, 1'b0, 32'h102, '0, 32'h0, 1'b1, 1'b1);
    send("sb_100_fault", 1'b1, 2'b00, 1'b0, 32'h100, 32'h0000_0055, 32'h0, 1'b0, 1'b1);
    send("lw_top_fault", 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, '0, 32'h0, 1'b0, 1'b1);
    // Rejected stores above must have left word 0 untouched.
    send("lw_0_intact",  1'b0, 2'b10, 1'b0, 32'd0, '0, 32'h0000_0011, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int   pulses, bad, cyc;
    logic after_pulse, done;
    exp_t e;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd8; req_wdata = '0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.rdata = 32'h0000_0019; e.mis = 1'b0; e.flt = 1'b0; e.name = "b2b_lw_8";
      sb_q.push_back(e);
    end
    pulses = 0; bad = 0; cyc = 0; after_pulse = 1'b0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1 && req_ready !== 1'b0) bad++;
      if (after_pulse) begin
        after_pulse = 1'b0;
        if (busy !== 1'b0 || req_ready !== 1'b1) bad++;
        if (pulses == 3) begin
          req_valid = 1'b0;
          done = 1'b1;
        end
      end
      if (rsp_valid === 1'b1) begin
        pulses++;
        after_pulse = 1'b1;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (pulses != 3 || cyc != 12) begin
      errors++;
      $display("FAIL b2b_pulses: %0d pulses in %0d cycles, want 3 in 12", pulses, cyc);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_ready_idle: %0d cycles with wrong ready/busy, want 0", bad);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_extra: busy=%b rsp_valid=%b, want 0/0", busy, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_access();
    int stray;
    // Abort during ISSUE: the live strobe must fall without a clock edge.
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || busy !== 1'b0 || mem_addr !== '0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_issue: mem_read=%b busy=%b mem_addr=%h rsp_valid=%b, want 0/0/0/0",
               mem_read, busy, mem_addr, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    // Abort during WAIT.
    @(negedge clk);
    req_addr = 32'd8; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_entry: busy=%b before reset, want 1", busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write, mem_half, mem_byte} !== 4'b0 || busy !== 1'b0 ||
        rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_wait: strobes=%b busy=%b rsp_valid=%b ready=%b, want 0/0/0/1",
               {mem_read, mem_write, mem_half, mem_byte}, busy, rsp_valid, req_ready);
    end
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stray++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rst_no_rsp: %0d cycles with a response or busy, want 0", stray);
    end
    send("lw_0_after_rst", 1'b0, 2'b10, 1'b0, 32'd0, '0, 32'h0000_0011, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_byte_access();
    test_half_word_access();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses never arrived, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
